pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Multi-cycle fetch/decode/execute controller that owns the program counter.
//   Sits between instruction memory and the datapath.
//   Issues fetches at the PC, latches the instruction, and hands it to the datapath.
//   Waits for execution to finish, then advances the PC sequentially or by a signed
//   branch offset. Stops permanently on a halt instruction.
// PARAMETERS
//   ADDR_W     8      PC / instruction-address width (must be >= 8)
//   INSTR_W    16     instruction word width
//   RESET_VEC  0      PC value loaded on reset
// PORTS
//   CLK          in   1        system clock, rising edge
//   RESET        in   1        asynchronous, active-low reset
//   imem_req     out  1        fetch request; high throughout FETCH state
//   imem_addr    out  ADDR_W   fetch address (= pc)
//   imem_ack     in   1        memory accepted request; imem_data valid this cycle
//   imem_data    in   INSTR_W  fetched instruction word
//   instr        out  INSTR_W  latched current instruction
//   instr_valid  out  1        high while in DECODE: instr is presented to the datapath
//   stall        in   1        freeze request from the datapath/hazard logic
//   ex_done      in   1        datapath finished executing instr
//   branch       in   1        branch taken; qualified by ex_done
//   branch_off   in   8        signed two's-complement branch offset; qualified by ex_done
//   halt         in   1        halt instruction; qualified by ex_done
//   pc           out  ADDR_W   current program counter
//   retired      out  1        one-cycle pulse per completed instruction
//   state        out  2        FETCH=0, DECODE=1, EXEC=2, HALTED=3 (debug)
// BEHAVIOUR
//   Reset (async, RESET=0):
//   - pc=RESET_VEC, state=FETCH, instr=0, retired=0.
//   - imem_req, instr_valid, retired are low while RESET=0.
//   - Reset mid-transaction aborts it immediately. Fetch restarts at RESET_VEC
//     on the first edge after release.
//   Outputs:
//   - imem_req=(state==FETCH), instr_valid=(state==DECODE), imem_addr=pc.
//   - All other outputs are registered.
//   FETCH:
//   - Hold imem_req and imem_addr stable until imem_ack.
//   - On an edge with imem_ack=1: instr<=imem_data, go to DECODE.
//   - imem_ack outside FETCH is ignored.
//   - stall has no effect in FETCH.
//   DECODE:
//   - Lasts exactly 1 cycle, then EXEC.
//   - If stall=1: remain in DECODE, instr_valid stays high, instr stays unchanged.
//   EXEC:
//   - Wait for ex_done=1 with stall=0. ex_done while stall=1 is ignored.
//   - On completion, retired=1 for the next cycle only.
//   - halt=1: go to HALTED, pc unchanged. halt has priority over branch.
//   - branch=1: pc<=pc+1+sext(branch_off), mod 2^ADDR_W, then FETCH.
//   - otherwise: pc<=pc+1, mod 2^ADDR_W, then FETCH.
//   HALTED:
//   - Terminal state; only reset exits.
//   - imem_req=0; ex_done, branch, halt, imem_ack are ignored.
//   Arithmetic:
//   - branch_off is sign-extended to ADDR_W.
//   - Wrap-around is silent (FF+1->00 for ADDR_W=8).
//   - Offset -1 loops to the same instruction.
//   Latency:
//   - Minimum 3 cycles per instruction: ack in the first FETCH cycle, DECODE,
//     ex_done in the first EXEC cycle.
//   - Each ack-wait, stall, or ex_done-wait cycle adds 1.
//   Unused state encoding: none (all 4 codes are defined).
// TESTING
//   1. Reset release, ack and ex_done tied high, no branch:
//      -> imem_addr 00,01,02... at one instruction per 3 cycles; retired pulses each time.
//   2. pc=FE, sequential execution:
//      -> next fetches at FF, then 00 (wrap).
//   3. pc=10, branch=1, branch_off=8'hF0 -> next fetch at 01.
//      pc=05, branch_off=8'hFF -> next fetch at 05.
//   4. imem_ack delayed 4 cycles:
//      -> imem_req and imem_addr stable for those 4 cycles; instr captured only on ack.
//      stall=1 for 2 cycles in DECODE -> instr_valid high for 3 cycles.
//   5. In EXEC, ex_done=1 with halt=1 and branch=1:
//      -> HALTED, pc unchanged, retired pulses once; no further imem_req despite acks.
//   6. RESET low while in FETCH with imem_req=1:
//      -> imem_req drops asynchronously; after release, fetch at RESET_VEC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer, instruction memory and the datapath.
// The master modport is the sequencer side of the bundle; the slave modport is the memory/datapath side.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               stall;
  logic               ex_done;
  logic               branch;
  logic [7:0]         branch_off;
  logic               halt;
  logic [ADDR_W-1:0]  pc;
  logic               retired;
  logic [1:0]         state;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, retired, state,
    input  imem_ack, imem_data, stall, ex_done, branch, branch_off, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, retired, state,
    output imem_ack, imem_data, stall, ex_done, branch, branch_off, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller owning the program counter.
// state  | meaning
// FETCH  | imem_req high, wait for imem_ack, latch instruction
// DECODE | instr_valid high for one cycle (longer while stalled)
// EXEC   | wait for ex_done with stall low, then advance pc
// HALTED | terminal, only reset exits
module pc_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 16,
  parameter int RESET_VEC = 0
) (
  input logic             CLK,
  input logic             RESET,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               retired_q, retired_d;
  logic [ADDR_W-1:0]  off_ext;

  assign off_ext = ADDR_W'($signed(bus.branch_off));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= FETCH;
      pc_q      <= RST_PC;
      instr_q   <= '0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!bus.stall) state_d = EXEC;
      end
      EXEC: begin
        if (bus.ex_done && !bus.stall) begin
          retired_d = 1'b1;
          // halt wins over branch and leaves pc on the halting instruction
          if (bus.halt) begin
            state_d = HALTED;
          end else begin
            state_d = FETCH;
            if (bus.branch) pc_d = pc_q + ADDR_W'(1) + off_ext;
            else            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = state_q;
    endcase
  end

  // state_q already sits at FETCH during reset, so gate the request with RESET
  assign bus.imem_req    = RESET && (state_q == FETCH);
  assign bus.instr_valid = (state_q == DECODE);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.retired     = retired_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, wrap, branches, ack wait, stall, halt, reset.
module tb_pc_sequencer;

  logic CLK;
  logic RESET;
  int   errors;
  int   checks;

  pc_sequencer_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  pc_sequencer #(.ADDR_W(8), .INSTR_W(16), .RESET_VEC(0)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0000; bus.stall = 1'b0;
    bus.ex_done = 1'b1; bus.branch = 1'b0; bus.branch_off = 8'h00; bus.halt = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", bus.pc); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got=%h exp=0000", bus.instr); end
    checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL reset_retired got=%b exp=0", bus.retired); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_instr;
    for (int i = 0; i < 4; i++) begin
      exp_instr = 16'hA500 | 16'(i);
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_req i=%0d got=%b exp=1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 8'(i)) begin errors++; $display("FAIL seq_addr got=%h exp=%h", bus.imem_addr, 8'(i)); end
      checks++; if (bus.retired !== (i != 0)) begin errors++; $display("FAIL seq_retired i=%0d got=%b exp=%b", i, bus.retired, (i != 0)); end
      bus.imem_data = exp_instr;
      step();
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid i=%0d got=%b exp=1", i, bus.instr_valid); end
      checks++; if (bus.instr !== exp_instr) begin errors++; $display("FAIL seq_instr got=%h exp=%h", bus.instr, exp_instr); end
      step();
      checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL seq_exec i=%0d got=%0d exp=2", i, bus.state); end
      checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL seq_pulse i=%0d got=%b exp=0", i, bus.retired); end
      step();
    end
    checks++; if (bus.pc !== 8'h04) begin errors++; $display("FAIL seq_pc_end got=%h exp=04", bus.pc); end
  endtask

  task automatic test_wrap();
    bus.branch = 1'b1; bus.branch_off = 8'hF9;
    repeat (3) step();
    bus.branch = 1'b0;
    checks++; if (bus.imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_fe got=%h exp=FE", bus.imem_addr); end
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff got=%h exp=FF", bus.imem_addr); end
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_00 got=%h exp=00", bus.imem_addr); end
    checks++; if (bus.retired !== 1'b1) begin errors++; $display("FAIL wrap_retired got=%b exp=1", bus.retired); end
  endtask

  task automatic test_branch();
    bus.imem_data = 16'hB00B;
    bus.branch = 1'b1;
    bus.branch_off = 8'h0F;
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'h10) begin errors++; $display("FAIL br_fwd got=%h exp=10", bus.imem_addr); end
    bus.branch_off = 8'hF0;
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'h01) begin errors++; $display("FAIL br_back got=%h exp=01", bus.imem_addr); end
    bus.branch_off = 8'h03;
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'h05) begin errors++; $display("FAIL br_to5 got=%h exp=05", bus.imem_addr); end
    bus.branch_off = 8'hFF;
    repeat (3) step();
    checks++; if (bus.imem_addr !== 8'h05) begin errors++; $display("FAIL br_self got=%h exp=05", bus.imem_addr); end
    bus.branch = 1'b0;
  endtask

  task automatic test_ack_stall();
    bus.imem_ack = 1'b0;
    bus.ex_done = 1'b0;
    bus.imem_data = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req i=%0d got=%b exp=1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 8'h05) begin errors++; $display("FAIL wait_addr i=%0d got=%h exp=05", i, bus.imem_addr); end
      checks++; if (bus.instr !== 16'hB00B) begin errors++; $display("FAIL wait_instr i=%0d got=%h exp=B00B", i, bus.instr); end
      step();
    end
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr !== 16'hDEAD) begin errors++; $display("FAIL ack_instr got=%h exp=DEAD", bus.instr); end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_v0 got=%b exp=1", bus.instr_valid); end
    bus.stall = 1'b1;
    bus.imem_data = 16'h5555;
    step();
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_v1 got=%b exp=1", bus.instr_valid); end
    step();
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_v2 got=%b exp=1", bus.instr_valid); end
    checks++; if (bus.instr !== 16'hDEAD) begin errors++; $display("FAIL stall_instr got=%h exp=DEAD", bus.instr); end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL stall_exec got=%0d exp=2", bus.state); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stall_v3 got=%b exp=0", bus.instr_valid); end
    bus.stall = 1'b1;
    bus.ex_done = 1'b1;
    step();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL exdone_stalled got=%0d exp=2", bus.state); end
    checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL exdone_stalled_ret got=%b exp=0", bus.retired); end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 8'h06) begin errors++; $display("FAIL exdone_pc got=%h exp=06", bus.pc); end
    checks++; if (bus.retired !== 1'b1) begin errors++; $display("FAIL exdone_ret got=%b exp=1", bus.retired); end
  endtask

  task automatic test_halt();
    bus.imem_ack = 1'b1;
    step();
    bus.halt = 1'b1; bus.branch = 1'b1; bus.branch_off = 8'h10;
    step();
    step();
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL halt_state got=%0d exp=3", bus.state); end
    checks++; if (bus.pc !== 8'h06) begin errors++; $display("FAIL halt_pc got=%h exp=06", bus.pc); end
    checks++; if (bus.retired !== 1'b1) begin errors++; $display("FAIL halt_ret got=%b exp=1", bus.retired); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halt_req got=%b exp=0", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL halted_state i=%0d got=%0d exp=3", i, bus.state); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL halted_req i=%0d got=%b exp=0", i, bus.imem_req); end
      checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL halted_ret i=%0d got=%b exp=0", i, bus.retired); end
      checks++; if (bus.pc !== 8'h06) begin errors++; $display("FAIL halted_pc i=%0d got=%h exp=06", i, bus.pc); end
    end
    bus.halt = 1'b0; bus.branch = 1'b0;
  endtask

  task automatic test_reset_mid();
    RESET = 1'b0;
    #3;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_exit_state got=%0d exp=0", bus.state); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_exit_pc got=%h exp=00", bus.pc); end
    repeat (3) step();
    bus.imem_ack = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mid_req_pre got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 8'h01) begin errors++; $display("FAIL mid_addr_pre got=%h exp=01", bus.imem_addr); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_async got=%b exp=0", bus.imem_req); end
    checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL mid_pc_async got=%h exp=00", bus.pc); end
    @(negedge CLK);
    RESET = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h7777;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mid_req_post got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL mid_addr_post got=%h exp=00", bus.imem_addr); end
    step();
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL mid_decode got=%0d exp=1", bus.state); end
    checks++; if (bus.instr !== 16'h7777) begin errors++; $display("FAIL mid_instr got=%h exp=7777", bus.instr); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_ack_stall();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
